// File: rtl/siwo_sequencer_if.sv
// Handshake bundle between the SIWO control side and the program sequencer.
// The breakpoint signals exist only when SIWO_SEQ_BREAKPOINT_EN is defined.
interface siwo_sequencer_if #(
    parameter int ADDR_WIDTH  = 10,
    parameter int COUNT_WIDTH = 16
);
    logic                   _start;
    logic                   _halt;
    logic                   _stall;
    logic                   _branchJump;
    logic                   _relative;
    logic [ADDR_WIDTH-1:0]  _destBranchJump;
`ifdef SIWO_SEQ_BREAKPOINT_EN
    logic                   _bpEnable;
    logic [ADDR_WIDTH-1:0]  _bpAddr;
`endif
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   insnValid;
    logic                   running;
    logic                   done;
    logic [COUNT_WIDTH-1:0] insnCount;
    logic [COUNT_WIDTH-1:0] cycleCount;

    // Control side: drives requests, observes sequencer status.
    modport master (
`ifdef SIWO_SEQ_BREAKPOINT_EN
        output _bpEnable, _bpAddr,
`endif
        output _start, _halt, _stall, _branchJump, _relative, _destBranchJump,
        input  pc, insnValid, running, done, insnCount, cycleCount
    );

    modport slave (
`ifdef SIWO_SEQ_BREAKPOINT_EN
        input  _bpEnable, _bpAddr,
`endif
        input  _start, _halt, _stall, _branchJump, _relative, _destBranchJump,
        output pc, insnValid, running, done, insnCount, cycleCount
    );
endinterface

// File: rtl/siwo_sequencer.sv
// Program sequencer: run/halt FSM, PC with absolute/relative branches, stall, and
// saturating retired/cycle counters. Optional breakpoint support: SIWO_SEQ_BREAKPOINT_EN.
module siwo_sequencer #(
    parameter int ADDR_WIDTH  = 10,
    parameter int COUNT_WIDTH = 16,
    parameter int START_ADDR  = 0
) (
    input logic                _CLK,
    input logic                _reset,
    siwo_sequencer_if.slave    bus
);
    localparam logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(START_ADDR);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
`ifdef SIWO_SEQ_BREAKPOINT_EN
        ,S_PAUSED = 2'd3
`endif
    } state_t;

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [COUNT_WIDTH-1:0] r_insn_count;
    logic [COUNT_WIDTH-1:0] r_cycle_count;

    logic [ADDR_WIDTH-1:0]  w_target;
    logic [COUNT_WIDTH-1:0] w_insn_inc;
    logic [COUNT_WIDTH-1:0] w_cycle_inc;
    logic                   w_running;
    logic                   w_bp_hit;

    // Offset is two's complement; modulo-2^ADDR_WIDTH addition handles negatives.
    assign w_target    = bus._relative ? (r_pc + bus._destBranchJump) : bus._destBranchJump;
    assign w_insn_inc  = (&r_insn_count)  ? r_insn_count  : r_insn_count  + 1'b1;
    assign w_cycle_inc = (&r_cycle_count) ? r_cycle_count : r_cycle_count + 1'b1;
    assign w_running   = (r_state == S_RUN);

`ifdef SIWO_SEQ_BREAKPOINT_EN
    // Set on resume so the instruction we paused on is allowed to execute once.
    logic r_bp_skip;
    assign w_bp_hit = w_running && !bus._stall && bus._bpEnable
                      && (r_pc == bus._bpAddr) && !r_bp_skip;
`else
    assign w_bp_hit = 1'b0;
`endif

    always_ff @(posedge _CLK) begin
        if (_reset) begin
            r_state       <= S_IDLE;
            r_pc          <= START_PC;
            r_insn_count  <= '0;
            r_cycle_count <= '0;
`ifdef SIWO_SEQ_BREAKPOINT_EN
            r_bp_skip     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (bus._start) begin
                        r_state       <= S_RUN;
                        r_pc          <= START_PC;
                        r_insn_count  <= '0;
                        r_cycle_count <= '0;
`ifdef SIWO_SEQ_BREAKPOINT_EN
                        r_bp_skip     <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    if (w_bp_hit) begin
`ifdef SIWO_SEQ_BREAKPOINT_EN
                        r_state <= S_PAUSED;
`endif
                    end else begin
                        r_cycle_count <= w_cycle_inc;
                        if (!bus._stall) begin
                            r_insn_count <= w_insn_inc;
`ifdef SIWO_SEQ_BREAKPOINT_EN
                            r_bp_skip    <= 1'b0;
`endif
                            if (bus._halt) begin
                                r_state <= S_HALTED;
                            end else if (bus._branchJump) begin
                                r_pc <= w_target;
                            end else begin
                                r_pc <= r_pc + 1'b1;
                            end
                        end
                    end
                end
`ifdef SIWO_SEQ_BREAKPOINT_EN
                S_PAUSED: begin
                    if (bus._start) begin
                        r_state   <= S_RUN;
                        r_bp_skip <= 1'b1;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.pc         = r_pc;
    assign bus.running    = w_running;
    assign bus.done       = (r_state == S_HALTED);
    assign bus.insnValid  = w_running && !bus._stall && !w_bp_hit;
    assign bus.insnCount  = r_insn_count;
    assign bus.cycleCount = r_cycle_count;
endmodule
